reorder_buffer: RTL and testbench

//  Circular in-order retirement queue of the out-of-order core. Allocates an entry per decoded instr,

---
 rtl/reorder_buffer.sv | 191 +++++++++++++++++++
 tb/tb_reorder_buffer.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/reorder_buffer.sv
// In-order retirement queue: allocates at tail, captures CDB results, retires one head entry per cycle.
// Commit outputs appear one cycle after retirement; rob_full blocks issue and rdy_in=0 freezes all state.
module reorder_buffer #(
  parameter int ROB_WIDTH_BIT = 3
) (
  input  logic                     clk_in,
  input  logic                     rst_n_in,
  input  logic                     rdy_in,
  input  logic                     issue_valid,
  input  logic [1:0]               issue_type,
  input  logic [4:0]               issue_rd,
  input  logic                     issue_ready,
  input  logic [31:0]              issue_val,
  input  logic                     issue_pred_jump,
  output logic                     rob_full,
  output logic [ROB_WIDTH_BIT-1:0] issue_rob_id,
  output logic [4:0]               set_dep_reg_id,
  output logic [ROB_WIDTH_BIT-1:0] set_dep_rob_id,
  input  logic                     cdb_valid,
  input  logic [ROB_WIDTH_BIT-1:0] cdb_rob_id,
  input  logic [31:0]              cdb_val,
  input  logic                     cdb_jump,
  input  logic [31:0]              cdb_addr,
  input  logic [ROB_WIDTH_BIT-1:0] get_rob_id1,
  input  logic [ROB_WIDTH_BIT-1:0] get_rob_id2,
  output logic                     rob_value1_ready,
  output logic [31:0]              rob_value1,
  output logic                     rob_value2_ready,
  output logic [31:0]              rob_value2,
  output logic [4:0]               set_reg_id,
  output logic [31:0]              set_val,
  output logic [ROB_WIDTH_BIT-1:0] set_reg_on_rob_id,
  output logic                     store_commit,
  output logic [ROB_WIDTH_BIT-1:0] store_rob_id,
  output logic                     rob_clear,
  output logic [31:0]              clear_pc,
  output logic                     halt_out
);
  localparam int W = ROB_WIDTH_BIT;
  localparam int ROB_SIZE = 1 << W;
  localparam logic [W:0] FULL_CNT = (W+1)'(ROB_SIZE);
  localparam logic [1:0] T_REG = 2'd0, T_STORE = 2'd1, T_BRANCH = 2'd2, T_HALT = 2'd3;

  logic [W-1:0]        head_q, head_d, tail_q, tail_d;
  logic [W:0]          count_q, count_d;
  logic [ROB_SIZE-1:0] ent_vld_q, ent_vld_d, ent_rdy_q, ent_rdy_d;
  logic [ROB_SIZE-1:0] ent_pred_q, ent_pred_d, ent_jump_q, ent_jump_d;
  logic [1:0]          ent_typ_q  [ROB_SIZE];
  logic [1:0]          ent_typ_d  [ROB_SIZE];
  logic [4:0]          ent_rd_q   [ROB_SIZE];
  logic [4:0]          ent_rd_d   [ROB_SIZE];
  logic [31:0]         ent_val_q  [ROB_SIZE];
  logic [31:0]         ent_val_d  [ROB_SIZE];
  logic [31:0]         ent_addr_q [ROB_SIZE];
  logic [31:0]         ent_addr_d [ROB_SIZE];

  logic [4:0]   set_reg_id_q, set_reg_id_d;
  logic [31:0]  set_val_q, set_val_d, clear_pc_q, clear_pc_d;
  logic [W-1:0] set_reg_on_rob_id_q, set_reg_on_rob_id_d, store_rob_id_q, store_rob_id_d;
  logic         store_commit_q, store_commit_d, rob_clear_q, rob_clear_d, halt_q, halt_d;

  logic issue_acc, cdb_acc, commit, mispredict;
  logic cdb_hit1, cdb_hit2;

  assign rob_full          = (count_q == FULL_CNT);
  assign issue_rob_id      = tail_q;
  assign set_dep_rob_id    = tail_q;
  assign set_dep_reg_id    = (issue_valid && !rob_full && !rob_clear_q && issue_type == T_REG) ? issue_rd : 5'd0;
  assign set_reg_id        = set_reg_id_q;
  assign set_val           = set_val_q;
  assign set_reg_on_rob_id = set_reg_on_rob_id_q;
  assign store_commit      = store_commit_q;
  assign store_rob_id      = store_rob_id_q;
  assign rob_clear         = rob_clear_q;
  assign clear_pc          = clear_pc_q;
  assign halt_out          = halt_q;

  // A same-cycle broadcast on the looked-up id beats the stored (possibly stale) value.
  assign cdb_hit1         = cdb_valid && !rob_clear_q && cdb_rob_id == get_rob_id1 && ent_vld_q[get_rob_id1];
  assign cdb_hit2         = cdb_valid && !rob_clear_q && cdb_rob_id == get_rob_id2 && ent_vld_q[get_rob_id2];
  assign rob_value1_ready = cdb_hit1 || (ent_vld_q[get_rob_id1] && ent_rdy_q[get_rob_id1]);
  assign rob_value2_ready = cdb_hit2 || (ent_vld_q[get_rob_id2] && ent_rdy_q[get_rob_id2]);
  assign rob_value1       = cdb_hit1 ? cdb_val : (ent_vld_q[get_rob_id1] ? ent_val_q[get_rob_id1] : 32'd0);
  assign rob_value2       = cdb_hit2 ? cdb_val : (ent_vld_q[get_rob_id2] ? ent_val_q[get_rob_id2] : 32'd0);

  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    ent_vld_d  = ent_vld_q;
    ent_rdy_d  = ent_rdy_q;
    ent_pred_d = ent_pred_q;
    ent_jump_d = ent_jump_q;
    ent_typ_d  = ent_typ_q;
    ent_rd_d   = ent_rd_q;
    ent_val_d  = ent_val_q;
    ent_addr_d = ent_addr_q;

    issue_acc  = issue_valid && !rob_full && !rob_clear_q;
    cdb_acc    = cdb_valid && !rob_clear_q && ent_vld_q[cdb_rob_id];
    commit     = (count_q != '0) && ent_vld_q[head_q] && ent_rdy_q[head_q] && !rob_clear_q;
    mispredict = commit && ent_typ_q[head_q] == T_BRANCH && ent_jump_q[head_q] != ent_pred_q[head_q];

    if (cdb_acc) begin
      ent_rdy_d[cdb_rob_id]  = 1'b1;
      ent_val_d[cdb_rob_id]  = cdb_val;
      ent_jump_d[cdb_rob_id] = cdb_jump;
      ent_addr_d[cdb_rob_id] = cdb_addr;
    end
    if (issue_acc) begin
      ent_vld_d[tail_q]  = 1'b1;
      ent_rdy_d[tail_q]  = issue_ready;
      ent_typ_d[tail_q]  = issue_type;
      ent_rd_d[tail_q]   = issue_rd;
      ent_val_d[tail_q]  = issue_val;
      ent_pred_d[tail_q] = issue_pred_jump;
      ent_jump_d[tail_q] = 1'b0;
      ent_addr_d[tail_q] = 32'd0;
      tail_d             = tail_q + 1'b1;
    end
    if (commit) begin
      ent_vld_d[head_q] = 1'b0;
      ent_rdy_d[head_q] = 1'b0;
      head_d            = head_q + 1'b1;
    end
    count_d = count_q + {{W{1'b0}}, issue_acc} - {{W{1'b0}}, commit};

    set_reg_id_d        = (commit && ent_typ_q[head_q] == T_REG) ? ent_rd_q[head_q] : 5'd0;
    set_val_d           = (commit && ent_typ_q[head_q] == T_REG) ? ent_val_q[head_q] : 32'd0;
    set_reg_on_rob_id_d = (commit && ent_typ_q[head_q] == T_REG) ? head_q : '0;
    store_commit_d      = commit && ent_typ_q[head_q] == T_STORE;
    store_rob_id_d      = store_commit_d ? head_q : '0;
    rob_clear_d         = mispredict;
    clear_pc_d          = mispredict ? ent_addr_q[head_q] : 32'd0;
    halt_d              = halt_q || (commit && ent_typ_q[head_q] == T_HALT);

    // The flush also discards anything issued or written back at the same edge.
    if (mispredict) begin
      ent_vld_d = '0;
      ent_rdy_d = '0;
      head_d    = '0;
      tail_d    = '0;
      count_d   = '0;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      head_q              <= '0;
      tail_q              <= '0;
      count_q             <= '0;
      ent_vld_q           <= '0;
      ent_rdy_q           <= '0;
      ent_pred_q          <= '0;
      ent_jump_q          <= '0;
      for (int i = 0; i < ROB_SIZE; i++) begin
        ent_typ_q[i]  <= '0;
        ent_rd_q[i]   <= '0;
        ent_val_q[i]  <= '0;
        ent_addr_q[i] <= '0;
      end
      set_reg_id_q        <= '0;
      set_val_q           <= '0;
      set_reg_on_rob_id_q <= '0;
      store_commit_q      <= 1'b0;
      store_rob_id_q      <= '0;
      rob_clear_q         <= 1'b0;
      clear_pc_q          <= '0;
      halt_q              <= 1'b0;
    end else if (rdy_in) begin
      head_q              <= head_d;
      tail_q              <= tail_d;
      count_q             <= count_d;
      ent_vld_q           <= ent_vld_d;
      ent_rdy_q           <= ent_rdy_d;
      ent_pred_q          <= ent_pred_d;
      ent_jump_q          <= ent_jump_d;
      ent_typ_q           <= ent_typ_d;
      ent_rd_q            <= ent_rd_d;
      ent_val_q           <= ent_val_d;
      ent_addr_q          <= ent_addr_d;
      set_reg_id_q        <= set_reg_id_d;
      set_val_q           <= set_val_d;
      set_reg_on_rob_id_q <= set_reg_on_rob_id_d;
      store_commit_q      <= store_commit_d;
      store_rob_id_q      <= store_rob_id_d;
      rob_clear_q         <= rob_clear_d;
      clear_pc_q          <= clear_pc_d;
      halt_q              <= halt_d;
    end
  end
endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer: issue, writeback, lookup forwarding, fill/wrap, flush, freeze, reset.
module tb_reorder_buffer;
  logic        clk_in = 1'b0;
  logic        rst_n_in, rdy_in;
  logic        issue_valid, issue_ready, issue_pred_jump;
  logic [1:0]  issue_type;
  logic [4:0]  issue_rd;
  logic [31:0] issue_val;
  logic        rob_full;
  logic [2:0]  issue_rob_id, set_dep_rob_id;
  logic [4:0]  set_dep_reg_id;
  logic        cdb_valid, cdb_jump;
  logic [2:0]  cdb_rob_id, get_rob_id1, get_rob_id2;
  logic [31:0] cdb_val, cdb_addr;
  logic        rob_value1_ready, rob_value2_ready;
  logic [31:0] rob_value1, rob_value2;
  logic [4:0]  set_reg_id;
  logic [31:0] set_val, clear_pc;
  logic [2:0]  set_reg_on_rob_id, store_rob_id;
  logic        store_commit, rob_clear, halt_out;

  int errors = 0;
  int checks = 0;

  reorder_buffer #(.ROB_WIDTH_BIT(3)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in),
    .issue_valid(issue_valid), .issue_type(issue_type), .issue_rd(issue_rd),
    .issue_ready(issue_ready), .issue_val(issue_val), .issue_pred_jump(issue_pred_jump),
    .rob_full(rob_full), .issue_rob_id(issue_rob_id),
    .set_dep_reg_id(set_dep_reg_id), .set_dep_rob_id(set_dep_rob_id),
    .cdb_valid(cdb_valid), .cdb_rob_id(cdb_rob_id), .cdb_val(cdb_val),
    .cdb_jump(cdb_jump), .cdb_addr(cdb_addr),
    .get_rob_id1(get_rob_id1), .get_rob_id2(get_rob_id2),
    .rob_value1_ready(rob_value1_ready), .rob_value1(rob_value1),
    .rob_value2_ready(rob_value2_ready), .rob_value2(rob_value2),
    .set_reg_id(set_reg_id), .set_val(set_val), .set_reg_on_rob_id(set_reg_on_rob_id),
    .store_commit(store_commit), .store_rob_id(store_rob_id),
    .rob_clear(rob_clear), .clear_pc(clear_pc), .halt_out(halt_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Step one active edge and land 1ns after it, clear of the edge.
  task automatic cyc();
    @(posedge clk_in);
    #1;
  endtask

  task automatic set_issue(input logic [1:0] t, input logic [4:0] rd, input logic rdy,
                           input logic [31:0] v, input logic pred);
    issue_valid = 1'b1; issue_type = t; issue_rd = rd;
    issue_ready = rdy; issue_val = v; issue_pred_jump = pred;
  endtask

  task automatic set_cdb(input logic [2:0] id, input logic [31:0] v, input logic j, input logic [31:0] a);
    cdb_valid = 1'b1; cdb_rob_id = id; cdb_val = v; cdb_jump = j; cdb_addr = a;
  endtask

  initial begin
    rst_n_in = 1'b0; rdy_in = 1'b1;
    issue_valid = 0; issue_type = 0; issue_rd = 0; issue_ready = 0; issue_val = 0; issue_pred_jump = 0;
    cdb_valid = 0; cdb_rob_id = 0; cdb_val = 0; cdb_jump = 0; cdb_addr = 0;
    get_rob_id1 = 0; get_rob_id2 = 0;
    #2;
    chk("rst_full", rob_full, 0);
    chk("rst_issue_id", issue_rob_id, 0);
    chk("rst_set_reg", set_reg_id, 0);
    chk("rst_store", store_commit, 0);
    chk("rst_clear", rob_clear, 0);
    chk("rst_halt", halt_out, 0);
    chk("rst_lookup_rdy", rob_value1_ready, 0);
    chk("rst_lookup_val", rob_value1, 0);
    #10 rst_n_in = 1'b1;
    cyc();

    // Single REG: issue id0, CDB writeback, commit
    set_issue(2'd0, 5'd5, 1'b0, 32'd0, 1'b0);
    #1;
    chk("dep_reg", set_dep_reg_id, 5);
    chk("dep_rob", set_dep_rob_id, 0);
    cyc();
    issue_valid = 1'b0;
    set_cdb(3'd0, 32'h1234, 1'b0, 32'd0);
    get_rob_id1 = 3'd0;
    #1;
    chk("fwd_rdy_id0", rob_value1_ready, 1);
    chk("fwd_val_id0", rob_value1, 32'h1234);
    cyc();
    cdb_valid = 1'b0;
    chk("no_early_commit", set_reg_id, 0);
    cyc();
    chk("commit_rd", set_reg_id, 5);
    chk("commit_val", set_val, 32'h1234);
    chk("commit_robid", set_reg_on_rob_id, 0);
    cyc();
    chk("commit_pulse_end", set_reg_id, 0);

    // Fill all 8 slots starting at id1; tail wraps 7 -> 0 -> 1
    for (int i = 0; i < 7; i++) begin
      set_issue(2'd0, 5'(i + 1), 1'b0, 32'd0, 1'b0);
      cyc();
    end
    chk("tail_wrap", issue_rob_id, 0);
    chk("not_full_7", rob_full, 0);
    set_issue(2'd0, 5'd8, 1'b0, 32'd0, 1'b0);
    cyc();
    chk("full_8", rob_full, 1);
    set_issue(2'd0, 5'd9, 1'b0, 32'd0, 1'b0);
    #1;
    chk("dep_blocked_full", set_dep_reg_id, 0);
    cyc();
    issue_valid = 1'b0;
    chk("full_after_9th", rob_full, 1);
    chk("tail_after_9th", issue_rob_id, 1);
    set_cdb(3'd1, 32'h11, 1'b0, 32'd0);
    cyc();
    cdb_valid = 1'b0;
    cyc();
    chk("full_drop", rob_full, 0);
    chk("fill_commit_rd", set_reg_id, 1);
    chk("fill_commit_val", set_val, 32'h11);
    chk("fill_commit_id", set_reg_on_rob_id, 1);

    // Lookup forwarding from the CDB on id2; id3 stays not ready
    get_rob_id1 = 3'd2; get_rob_id2 = 3'd3;
    set_cdb(3'd2, 32'hABCD, 1'b0, 32'd0);
    #1;
    chk("fwd_rdy_id2", rob_value1_ready, 1);
    chk("fwd_val_id2", rob_value1, 32'hABCD);
    chk("lookup_id3_rdy", rob_value2_ready, 0);
    cyc();
    cdb_valid = 1'b0;
    #1;
    chk("stored_rdy_id2", rob_value1_ready, 1);
    chk("stored_val_id2", rob_value1, 32'hABCD);
    cyc();
    chk("commit_id2_rd", set_reg_id, 2);
    chk("commit_id2_val", set_val, 32'hABCD);
    set_cdb(3'd3, 32'h33, 1'b0, 32'd0);
    cyc();
    cdb_valid = 1'b0;
    cyc();
    chk("commit_id3_rd", set_reg_id, 3);

    // Asynchronous reset with 5 live entries (ids 4..7,0)
    get_rob_id1 = 3'd4;
    rst_n_in = 1'b0;
    #1;
    chk("arst_set_reg", set_reg_id, 0);
    chk("arst_set_val", set_val, 0);
    chk("arst_robid", set_reg_on_rob_id, 0);
    chk("arst_full", rob_full, 0);
    chk("arst_tail", issue_rob_id, 0);
    chk("arst_lookup", rob_value1_ready, 0);
    #3 rst_n_in = 1'b1;
    cyc();

    // Mispredicted branch at head flushes the younger ready REG
    set_issue(2'd2, 5'd0, 1'b0, 32'd0, 1'b0);
    cyc();
    set_issue(2'd0, 5'd7, 1'b1, 32'h77, 1'b0);
    cyc();
    issue_valid = 1'b0;
    set_cdb(3'd0, 32'd0, 1'b1, 32'h100);
    cyc();
    cdb_valid = 1'b0;
    cyc();
    chk("flush_pulse", rob_clear, 1);
    chk("flush_pc", clear_pc, 32'h100);
    chk("flush_tail", issue_rob_id, 0);
    chk("flush_no_reg", set_reg_id, 0);
    get_rob_id1 = 3'd1;
    set_issue(2'd0, 5'd9, 1'b1, 32'h99, 1'b0);
    #1;
    chk("flush_dep_blocked", set_dep_reg_id, 0);
    chk("flush_lookup_id1", rob_value1_ready, 0);
    cyc();
    issue_valid = 1'b0;
    chk("flush_pulse_end", rob_clear, 0);
    chk("flush_pc_end", clear_pc, 0);
    chk("flush_issue_ignored", issue_rob_id, 0);
    chk("flush_no_young", set_reg_id, 0);
    cyc();
    chk("flush_no_young2", set_reg_id, 0);

    // Out-of-order writeback, freeze, then STORE and HALT retirement
    set_issue(2'd0, 5'd10, 1'b0, 32'd0, 1'b0); cyc();
    set_issue(2'd0, 5'd11, 1'b0, 32'd0, 1'b0); cyc();
    set_issue(2'd1, 5'd0, 1'b1, 32'd0, 1'b0);  cyc();
    set_issue(2'd3, 5'd0, 1'b1, 32'd0, 1'b0);  cyc();
    issue_valid = 1'b0;
    set_cdb(3'd1, 32'hB1, 1'b0, 32'd0);
    cyc();
    chk("ooo_no_commit", set_reg_id, 0);
    set_cdb(3'd0, 32'hA0, 1'b0, 32'd0);
    cyc();
    cdb_valid = 1'b0;
    rdy_in = 1'b0;
    cyc();
    chk("freeze_no_commit", set_reg_id, 0);
    cyc();
    chk("freeze_no_commit2", set_reg_id, 0);
    rdy_in = 1'b1;
    cyc();
    chk("ooo_commit0_rd", set_reg_id, 10);
    chk("ooo_commit0_val", set_val, 32'hA0);
    chk("ooo_commit0_id", set_reg_on_rob_id, 0);
    rdy_in = 1'b0;
    cyc();
    chk("freeze_hold_rd", set_reg_id, 10);
    rdy_in = 1'b1;
    cyc();
    chk("ooo_commit1_rd", set_reg_id, 11);
    chk("ooo_commit1_val", set_val, 32'hB1);
    chk("ooo_commit1_id", set_reg_on_rob_id, 1);
    cyc();
    chk("store_pulse", store_commit, 1);
    chk("store_id", store_rob_id, 2);
    chk("store_no_reg", set_reg_id, 0);
    cyc();
    chk("store_pulse_end", store_commit, 0);
    chk("halt_set", halt_out, 1);
    cyc();
    chk("halt_sticky", halt_out, 1);
    chk("final_tail", issue_rob_id, 4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
